// File: rtl/db_mem_ctrl_pkg.sv
// Shared codes for the CPU data-bus controller: access types, access lengths,
// bus error codes and the controller FSM states.
package db_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_R    = 2'd1,
    ACC_W    = 2'd2,
    ACC_X    = 2'd3
  } mem_access_e;

  typedef enum logic [1:0] {
    LEN_B = 2'd0,
    LEN_H = 2'd1,
    LEN_W = 2'd2
  } mem_len_e;

  typedef enum logic [1:0] {
    BUS_ERR_NONE    = 2'd0,
    BUS_ERR_ALIGN   = 2'd1,
    BUS_ERR_TIMEOUT = 2'd2
  } bus_err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam int unsigned BUS_TIMEOUT = 255;

  // The unused length code 3 is treated like a word access.
  function automatic logic is_misaligned(input mem_len_e len, input logic [1:0] offset);
    case (len)
      LEN_B:   return 1'b0;
      LEN_H:   return offset[0];
      default: return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/db_mem_ctrl_if.sv
// CPU-side data bus (master = CPU) and memory-side bus (master = controller).
interface db_bus_if #(
  parameter int unsigned ADDR_W = 32
) ();
  import db_mem_ctrl_pkg::*;

  logic [ADDR_W-1:0] db_addr;
  mem_access_e       db_accessType;
  mem_len_e          db_memLen;
  logic [31:0]       db_dataOut;
  logic [31:0]       db_dataIn;
  logic              db_ready;
  logic              db_busErr;
  bus_err_e          db_errCode;

  modport master (
    output db_addr, db_accessType, db_memLen, db_dataOut,
    input  db_dataIn, db_ready, db_busErr, db_errCode
  );

  modport slave (
    input  db_addr, db_accessType, db_memLen, db_dataOut,
    output db_dataIn, db_ready, db_busErr, db_errCode
  );
endinterface

interface mem_bus_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/db_mem_ctrl_bus_lane_align.sv
// Little-endian lane steering between right-aligned CPU data and a 32-bit
// memory word: byte enables, write replication, read extraction, alignment.
module bus_lane_align
  import db_mem_ctrl_pkg::*;
(
  input  mem_len_e    len,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_aligned,
  output logic        misaligned
);
  logic [31:0] rdata_b;
  logic [31:0] rdata_h;

  assign rdata_b    = rdata >> {offset, 3'b000};
  assign rdata_h    = rdata >> {offset[1], 4'b0000};
  assign misaligned = is_misaligned(len, offset);

  always_comb begin
    be            = 4'b1111;
    wdata_rep     = wdata;
    rdata_aligned = rdata;
    case (len)
      LEN_B: begin
        be            = 4'b0001 << offset;
        wdata_rep     = {4{wdata[7:0]}};
        rdata_aligned = {24'b0, rdata_b[7:0]};
      end
      LEN_H: begin
        be            = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep     = {2{wdata[15:0]}};
        rdata_aligned = {16'b0, rdata_h[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/db_mem_ctrl.sv
// CPU data-bus to word-addressed memory controller: one memory transaction per
// CPU access, with alignment and timeout failures returned as bus errors.
module db_mem_ctrl
  import db_mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = BUS_TIMEOUT,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic      clk,
  input  logic      res,
  db_bus_if.slave   db,
  mem_bus_if.master mem
);
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  bus_err_e          err_q, err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              ready_q, ready_d;
  logic              bus_err_q, bus_err_d;
  bus_err_e          err_code_q, err_code_d;
  logic [31:0]       data_in_q, data_in_d;
  mem_len_e          len_q, len_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rdata_q, rdata_d;

  mem_len_e    lane_len;
  logic [1:0]  lane_off;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;
  logic        lane_misaligned;

  // In IDLE the lanes decode the live request; afterwards the latched one.
  assign lane_len = (state_q == ST_IDLE) ? db.db_memLen    : len_q;
  assign lane_off = (state_q == ST_IDLE) ? db.db_addr[1:0] : off_q;

  bus_lane_align u_lane (
    .len           (lane_len),
    .offset        (lane_off),
    .wdata         (db.db_dataOut),
    .rdata         (mem.mem_rdata),
    .be            (lane_be),
    .wdata_rep     (lane_wdata),
    .rdata_aligned (lane_rdata),
    .misaligned    (lane_misaligned)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    ready_d     = 1'b0;
    bus_err_d   = 1'b0;
    err_code_d  = BUS_ERR_NONE;
    data_in_d   = data_in_q;
    len_d       = len_q;
    off_d       = off_q;
    rdata_d     = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (db.db_accessType != ACC_NONE) begin
          if (lane_misaligned) begin
            state_d = ST_ERR;
            err_d   = BUS_ERR_ALIGN;
          end else begin
            state_d     = ST_REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = (db.db_accessType == ACC_W);
            mem_addr_d  = db.db_addr[ADDR_W-1:2];
            mem_be_d    = lane_be;
            mem_wdata_d = lane_wdata;
            len_d       = db.db_memLen;
            off_d       = db.db_addr[1:0];
          end
        end
      end
      ST_REQ: begin
        // An ack arriving on the expiry cycle still completes normally.
        if (mem.mem_ack) begin
          rdata_d   = lane_rdata;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = BUS_ERR_TIMEOUT;
          state_d   = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        ready_d   = 1'b1;
        data_in_d = rdata_q;
        state_d   = ST_IDLE;
      end
      ST_ERR: begin
        ready_d    = 1'b1;
        bus_err_d  = 1'b1;
        err_code_d = err_q;
        data_in_d  = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      err_q       <= BUS_ERR_NONE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      ready_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      err_code_q  <= BUS_ERR_NONE;
      data_in_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      ready_q     <= ready_d;
      bus_err_q   <= bus_err_d;
      err_code_q  <= err_code_d;
      data_in_q   <= data_in_d;
    end
  end

  always_ff @(posedge clk) begin
    len_q   <= len_d;
    off_q   <= off_d;
    rdata_q <= rdata_d;
  end

  assign mem.mem_req    = mem_req_q;
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_be     = mem_be_q;
  assign mem.mem_wdata  = mem_wdata_q;
  assign db.db_ready    = ready_q;
  assign db.db_busErr   = bus_err_q;
  assign db.db_errCode  = err_code_q;
  assign db.db_dataIn   = data_in_q;

endmodule
